conv_window_scan: RTL

Upstream controller for the kernel offset counter of the convolution datapath. It sweeps the kernel window origin over the input image in raster order. For each window position it asserts `read_en` for exactly CON_SIZE×CON_SIZE consecutive cycles, so the downstream offset counter walks one full kernel per window. It reports the current window origin, marks the last element of each window, and pulses `done` when the frame is complete.

---
 rtl/conv_window_scan_if.sv | 30 +++
 rtl/conv_window_scan.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/conv_window_scan_if.sv
// Handshake/status bundle between a frame requester and conv_window_scan.
//   start    : requester -> scanner, one-cycle frame request
//   read_en  : scanner -> datapath, kernel element read strobe
//   win_row  : current window origin row
//   win_col  : current window origin column
//   win_last : last read_en cycle of the current window
//   busy     : frame in progress (through done)
//   done     : one-cycle end-of-frame pulse
// master: requester side; slave: scanner side.
interface conv_window_scan_if #(
  parameter int unsigned IMA_ADDR = 3
);
  logic                start;
  logic                read_en;
  logic [IMA_ADDR-1:0] win_row;
  logic [IMA_ADDR-1:0] win_col;
  logic                win_last;
  logic                busy;
  logic                done;

  modport master (
    output start,
    input  read_en, win_row, win_col, win_last, busy, done
  );

  modport slave (
    input  start,
    output read_en, win_row, win_col, win_last, busy, done
  );
endinterface

// File: rtl/conv_window_scan.sv
// conv_window_scan: sweeps the kernel window origin over the image in raster order
// (column fastest). For every window, read_en is held for CON_SIZE*CON_SIZE cycles so
// the downstream kernel offset counter walks exactly one kernel per window.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : conv_window_scan_if.slave (start in; read_en, win_row, win_col,
//           win_last, busy, done out; all outputs registered)
//
// Configuration macro WIN_GAP_EN: when defined, one read_en=0 cycle (GAP state) is
// inserted between consecutive windows, with the new origin already presented.
module conv_window_scan #(
  parameter int unsigned IMA_SIZE = 6,
  parameter int unsigned IMA_ADDR = 3,
  parameter int unsigned CON_SIZE = 3,
  parameter int unsigned CON_ADDR = 2,
  parameter int unsigned ELEM_W   = 4
) (
  input logic               clk,
  input logic               reset,
  conv_window_scan_if.slave bus
);

  localparam int unsigned Last = IMA_SIZE - CON_SIZE;
  localparam int unsigned K    = CON_SIZE * CON_SIZE;

  localparam logic [IMA_ADDR-1:0] LastPos  = IMA_ADDR'(Last);
  localparam logic [ELEM_W-1:0]   ElemLast = ELEM_W'(K - 1);

  // Elaboration-time sanity checks on the parameter set.
  if (CON_SIZE > IMA_SIZE) begin : g_bad_con_size
    $error("CON_SIZE must not exceed IMA_SIZE");
  end
  if (ELEM_W < $clog2(K)) begin : g_bad_elem_w
    $error("ELEM_W cannot hold CON_SIZE*CON_SIZE-1");
  end
  if (IMA_ADDR < $clog2(Last + 1)) begin : g_bad_ima_addr
    $error("IMA_ADDR cannot hold IMA_SIZE-CON_SIZE");
  end
  if (CON_ADDR < $clog2(CON_SIZE)) begin : g_bad_con_addr
    $error("CON_ADDR cannot hold CON_SIZE-1");
  end

`ifdef WIN_GAP_EN
  typedef enum logic [1:0] {StIdle, StRun, StGap, StFin} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;
`endif

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [IMA_ADDR-1:0] row_q, row_d;
  logic [IMA_ADDR-1:0] col_q, col_d;
  logic                read_en_q, win_last_q, busy_q, done_q;

  // Next-state logic for the FSM, element counter and window origin.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    row_d   = row_q;
    col_d   = col_q;

    unique case (state_q)
      StIdle: begin
        elem_d = '0;
        row_d  = '0;
        col_d  = '0;
        if (bus.start) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (elem_q == ElemLast) begin
          elem_d = '0;
          if (col_q < LastPos) begin
            col_d = col_q + IMA_ADDR'(1);
`ifdef WIN_GAP_EN
            state_d = StGap;
`endif
          end else if (row_q < LastPos) begin
            col_d = '0;
            row_d = row_q + IMA_ADDR'(1);
`ifdef WIN_GAP_EN
            state_d = StGap;
`endif
          end else begin
            // Final window: origin holds LAST through FIN.
            state_d = StFin;
          end
        end else begin
          elem_d = elem_q + ELEM_W'(1);
        end
      end

`ifdef WIN_GAP_EN
      StGap: begin
        state_d = StRun;
      end
`endif

      StFin: begin
        state_d = StIdle;
        row_d   = '0;
        col_d   = '0;
      end

      default: begin
        state_d = StIdle;
        elem_d  = '0;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

  // Status outputs are registered from the next-state values so they line up
  // with the state and origin they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      elem_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      read_en_q  <= 1'b0;
      win_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      row_q      <= row_d;
      col_q      <= col_d;
      read_en_q  <= (state_d == StRun);
      win_last_q <= (state_d == StRun) && (elem_d == ElemLast);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StFin);
    end
  end

  assign bus.read_en  = read_en_q;
  assign bus.win_row  = row_q;
  assign bus.win_col  = col_q;
  assign bus.win_last = win_last_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
